// File: rtl/clk_burst_gate_ctrl_if.sv
// Requester-side bundle of the burst gated-clock controller.
// Handshake: req_i is a level held until the matching gnt_o pulse; lengths are sampled on the granting edge.
interface clk_burst_gate_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       req_i;
    logic [CNT_W-1:0] len0_i;
    logic [CNT_W-1:0] len1_i;
    logic [1:0]       gnt_o;
    logic [1:0]       done_o;
    logic             busy_o;
    logic             active_o;
    logic             gclk_o;
    logic [1:0]       state_dbg;

    modport slave (
        input  req_i, len0_i, len1_i,
        output gnt_o, done_o, busy_o, active_o, gclk_o, state_dbg
    );

    modport master (
        output req_i, len0_i, len1_i,
        input  gnt_o, done_o, busy_o, active_o, gclk_o, state_dbg
    );
endinterface

// File: rtl/clk_burst_gate_ctrl.sv
// Round-robin burst arbiter driving one glitch-free gated clock (posedge enable, negedge re-time, AND).
// Two requesters each ask for N gated pulses; bursts are separated by GAP idle cycles.
module clk_burst_gate_ctrl #(
    parameter int CNT_W = 8,
    parameter int GAP   = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    clk_burst_gate_ctrl_if.slave bus
);
    localparam logic [1:0]       ST_IDLE = 2'd0;
    localparam logic [1:0]       ST_RUN  = 2'd1;
    localparam logic [1:0]       ST_GAP  = 2'd2;
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_en_q, gate_en_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             active_q, active_d;
    logic             busy_q;
    logic             en_neg;
    logic             win;
    logic [CNT_W-1:0] len_sel;

    // A zero-length grant still spends one RUN cycle (cnt=0) so done lands the cycle after gnt.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gate_en_d = gate_en_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        active_d  = active_q;
        win       = 1'b0;
        len_sel   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_i != 2'b00) begin
                    win       = (bus.req_i == 2'b11) ? ~active_q : bus.req_i[1];
                    len_sel   = win ? bus.len1_i : bus.len0_i;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    active_d  = win;
                    cnt_d     = len_sel;
                    gate_en_d = (len_sel != '0);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q <= CNT_ONE) begin
                    gate_en_d = 1'b0;
                    done_d    = active_q ? 2'b10 : 2'b01;
                    if ((cnt_q != '0) && (GAP > 0)) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                gate_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gate_en_q <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            active_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_en_q <= gate_en_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            active_q  <= active_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Re-timing on the falling edge keeps the enable stable across every clk high phase.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_neg <= 1'b0;
        end else begin
            en_neg <= gate_en_q;
        end
    end

    assign bus.gclk_o    = clk & en_neg;
    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = done_q;
    assign bus.busy_o    = busy_q;
    assign bus.active_o  = active_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_clk_burst_gate_ctrl.sv
// Bench for clk_burst_gate_ctrl: schedule-based reference model feeding expected-event queues,
// a negedge monitor for gnt/done/busy/active, and a quarter-period gclk sampler.
module tb_clk_burst_gate_ctrl;
  localparam int CNT_W = 8;
  localparam int GAP   = 2;
  localparam int MAXC  = 16384;
  localparam int W     = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clk_burst_gate_ctrl_if #(.CNT_W(CNT_W)) bus ();

  clk_burst_gate_ctrl #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  // entry = {cycle[22:0], len[7:0], requester}
  logic [W-1:0] gnt_q[$];
  logic [W-1:0] done_q[$];
  bit   pulse_exp [MAXC];
  bit   busy_exp  [MAXC];
  int   free_at     = 0;
  logic last_w      = 1'b1;
  logic exp_active  = 1'b1;
  int   pulse_total = 0;
  int   pulse_mark  = 0;
  logic gclk_prev   = 1'b0;
  int   checks      = 0;
  int   errors      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: at each arbitration opportunity, schedule the whole burst arithmetically.
  always @(negedge clk) begin : model
    int   c, len, dc;
    logic w;
    if (rst_n) begin
      c = cyc;
      if (c >= free_at && bus.req_i != 2'b00) begin
        w   = (bus.req_i == 2'b11) ? ~last_w : bus.req_i[1];
        len = w ? int'(bus.len1_i) : int'(bus.len0_i);
        dc  = (len == 0) ? c + 2 : c + len + 1;
        gnt_q.push_back({23'(c + 1), 8'd0, w});
        done_q.push_back({23'(dc), 8'(len), w});
        for (int k = 2; k <= len + 1; k++) if (c + k < MAXC) pulse_exp[c + k] = 1'b1;
        if (len == 0) begin
          if (c + 1 < MAXC) busy_exp[c + 1] = 1'b1;
          free_at = c + 2;
        end else begin
          for (int k = 1; k <= len + GAP; k++) if (c + k < MAXC) busy_exp[c + k] = 1'b1;
          free_at = c + len + 1 + GAP;
        end
        last_w = w;
      end
    end
  end

  // Reset aborts everything the model had scheduled.
  always @(negedge rst_n) begin
    for (int k = cyc; k < MAXC; k++) begin
      pulse_exp[k] = 1'b0;
      busy_exp[k]  = 1'b0;
    end
    gnt_q.delete();
    done_q.delete();
    free_at    = 0;
    last_w     = 1'b1;
    exp_active = 1'b1;
    pulse_mark = pulse_total;
  end

  task automatic check_stream(input bit sel, input logic [1:0] obs);
    logic [W-1:0] e;
    int           ec, el;
    logic         ew;
    string        nm;
    nm = sel ? "done" : "gnt";
    while ((sel ? done_q.size() : gnt_q.size()) > 0 &&
           int'((sel ? done_q[0] : gnt_q[0]) >> 9) < cyc) begin
      e = sel ? done_q.pop_front() : gnt_q.pop_front();
      check({nm, "_cycle"}, 32'(cyc), 32'(e >> 9));
    end
    if ((sel ? done_q.size() : gnt_q.size()) > 0 &&
        int'((sel ? done_q[0] : gnt_q[0]) >> 9) == cyc) begin
      e  = sel ? done_q.pop_front() : gnt_q.pop_front();
      ec = int'(e >> 9);
      el = int'(e[8:1]);
      ew = e[0];
      check(nm, 32'(obs), ew ? 32'h2 : 32'h1);
      if (sel) begin
        check("pulses", 32'(pulse_total - pulse_mark), 32'(el));
        pulse_mark = pulse_total;
      end else begin
        exp_active = ew;
      end
    end else if (obs != 2'b00) begin
      check({nm, "_unexpected"}, 32'(obs), 32'h0);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check_stream(1'b0, bus.gnt_o);
      check_stream(1'b1, bus.done_o);
      check("busy", 32'(bus.busy_o), 32'(busy_exp[cyc]));
      check("active", 32'(bus.active_o), 32'(exp_active));
    end
  end

  // gclk sampler at +1, +3 (high phase) and +5, +7 (low phase) after each rising edge.
  task automatic sample_gclk();
    logic e;
    e = clk && rst_n && pulse_exp[cyc];
    check("gclk", 32'(bus.gclk_o), 32'(e));
    if (bus.gclk_o && !gclk_prev) pulse_total++;
    gclk_prev = bus.gclk_o;
  endtask

  always @(posedge clk) begin
    #1 sample_gclk();
    #2 sample_gclk();
    #2 sample_gclk();
    #2 sample_gclk();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input bit sel, input int i, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      tick();
      hit = sel ? bus.done_o[i] : bus.gnt_o[i];
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_%s%0d: no pulse within %0d cycles", sel ? "done" : "gnt", i, budget);
    end
  endtask

  task automatic check_reset_state();
    check("rst_gnt", 32'(bus.gnt_o), 32'h0);
    check("rst_done", 32'(bus.done_o), 32'h0);
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    check("rst_active", 32'(bus.active_o), 32'h1);
    check("rst_gclk", 32'(bus.gclk_o), 32'h0);
  endtask

  task automatic do_reset();
    bus.req_i = 2'b00;
    rst_n     = 1'b0;
    tick();
    tick();
    check_reset_state();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int ncyc);
    logic [1:0] r;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      r = bus.req_i;
      for (int i = 0; i < 2; i++) begin
        if (bus.gnt_o[i]) begin
          r[i] = 1'b0;
        end else if (!r[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            r[i] = 1'b1;
            if (i == 0) bus.len0_i = CNT_W'($urandom_range(0, 7));
            else        bus.len1_i = CNT_W'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 31) == 0) begin
          r[i] = 1'b0;
        end
      end
      bus.req_i = r;
      if ($urandom_range(0, 7) == 0) bus.len0_i = CNT_W'($urandom_range(0, 7));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_i  = 2'b00;
    bus.len0_i = '0;
    bus.len1_i = '0;
    do_reset();

    // single request, len 4
    bus.len0_i = 8'd4;
    bus.req_i  = 2'b01;
    wait_pulse(1'b0, 0, 20);
    bus.req_i = 2'b00;
    wait_pulse(1'b1, 0, 20);
    repeat (5) tick();

    // both requesting, alternating 0,1,0,1
    do_reset();
    bus.len0_i = 8'd3;
    bus.len1_i = 8'd5;
    bus.req_i  = 2'b11;
    wait_pulse(1'b0, 0, 20); bus.req_i[0] = 1'b0;
    wait_pulse(1'b1, 0, 20); bus.req_i[0] = 1'b1;
    wait_pulse(1'b0, 1, 20); bus.req_i[1] = 1'b0;
    wait_pulse(1'b1, 1, 20); bus.req_i[1] = 1'b1;
    wait_pulse(1'b0, 0, 20); bus.req_i[0] = 1'b0;
    wait_pulse(1'b1, 0, 20);
    wait_pulse(1'b0, 1, 20); bus.req_i[1] = 1'b0;
    wait_pulse(1'b1, 1, 20);
    repeat (5) tick();

    // zero-length burst on requester 1
    bus.len1_i = 8'd0;
    bus.req_i  = 2'b10;
    wait_pulse(1'b0, 1, 20);
    bus.req_i = 2'b00;
    wait_pulse(1'b1, 1, 5);
    repeat (4) tick();

    // reset during the 3rd pulse of an 8-pulse burst
    bus.len0_i = 8'd8;
    bus.req_i  = 2'b01;
    wait_pulse(1'b0, 0, 20);
    bus.req_i = 2'b00;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1 check("abort_gclk", 32'(bus.gclk_o), 32'h0);
    tick();
    check_reset_state();
    tick();
    rst_n = 1'b1;
    repeat (15) tick();

    // length and requester-1 changes during RUN are ignored
    bus.len0_i = 8'd6;
    bus.req_i  = 2'b01;
    wait_pulse(1'b0, 0, 20);
    bus.req_i = 2'b00;
    tick();
    tick();
    bus.len0_i = 8'd2;
    bus.req_i  = 2'b10;
    tick();
    bus.req_i = 2'b00;
    wait_pulse(1'b1, 0, 20);
    repeat (5) tick();

    // maximum-length burst
    bus.len0_i = 8'd255;
    bus.req_i  = 2'b01;
    wait_pulse(1'b0, 0, 20);
    bus.req_i = 2'b00;
    wait_pulse(1'b1, 0, 300);
    repeat (5) tick();

    random_phase(3000);

    bus.req_i = 2'b00;
    repeat (40) tick();
    check("gnt_q_left", 32'(gnt_q.size()), 32'h0);
    check("done_q_left", 32'(done_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
